csr_access_arbiter: RTL and testbench
=====================================

# csr_access_arbiter

Arbitrates and sequences all accesses to the machine CSR file. It takes CSR read/write requests from two requesters, the core commit port (`core_`) and the debug/memory-mapped port (`dbg_`), and grants them round-robin. It issues exactly one single-cycle `valid` beat per access to the CSR file, waits for `done`, and returns data and the exception flag to the originator. No access is issued in a cycle where a trap or mret is updating CSR state, so trap updates never shadow a CSR write.

## Interface
- `TIMEOUT`, default 15: cycles spent in WAIT without `done` before a forced exception response. Must be ≥ 2.
- `DBG_ENABLE`, default 1: 0 ties `dbg_req_ready_o` and `dbg_rsp_valid_o` to 0; `dbg_` inputs are ignored.

Ports (name, direction, width, meaning):
- `cpu_clock_i` in 1: the single clock.
- `cpu_reset_i` in 1: synchronous, active-high reset.
- `core_req_valid_i` / `dbg_req_valid_i` in 1: request pending.
- `core_req_ready_o` / `dbg_req_ready_o` out 1: request accepted this cycle.
- `core_req_addr_i` / `dbg_req_addr_i` in 12: CSR address.
- `core_req_op_i` / `dbg_req_op_i` in 2: 01 RW, 10 RS, 11 RC.
- `core_req_wr_i` / `dbg_req_wr_i` in 1: access writes.
- `core_req_data_i` / `dbg_req_data_i` in 32: write operand.
- `core_flush_i` in 1: pipeline flush for the core requester.
- `trap_pending_i` in 1: mret, exception or interrupt takes effect in the CSR file this cycle.
- `csr_valid_o` out 1, `csr_addr_o` out 12, `csr_op_o` out 2, `csr_wr_o` out 1, `csr_data_o` out 32: drive the CSR file.
- `csr_done_i` in 1, `csr_excp_i` in 1, `csr_rdata_i` in 32: CSR file response. `done` is registered one cycle after `valid`.
- `core_rsp_valid_o` / `dbg_rsp_valid_o` out 1: response available.
- `core_rsp_ready_i` / `dbg_rsp_ready_i` in 1: response consumed.
- `rsp_data_o` out 32, `rsp_excp_o` out 1: response payload, shared by both requesters.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset values:
  - state = IDLE
  - `last_grant` = dbg, so the core port wins the first tie
  - all outputs 0
  - response payload and registered request fields 0
- IDLE:
  - Eligible requesters: `core_req_valid_i & !core_flush_i`, and `dbg_req_valid_i & DBG_ENABLE`.
  - Grant rules: one eligible requester is granted alone. If both are eligible, grant the one not named by `last_grant`.
  - On grant: pulse the matching `req_ready` combinationally, latch addr/op/wr/data and the owner, update `last_grant`, go to ISSUE.
  - No grant is given while `trap_pending_i` is high.
- ISSUE:
  - If `trap_pending_i` is high, keep `csr_valid_o` low and stay in ISSUE.
  - Otherwise drive `csr_valid_o`=1 for exactly this cycle, with the latched fields on `csr_*`, clear the timeout counter, and go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - On `csr_done_i`: capture `csr_rdata_i` and `csr_excp_i`, go to RESP.
  - If the counter reaches `TIMEOUT`: capture data=0, excp=1, go to RESP.
- RESP:
  - The owner's `rsp_valid` is held high until its `rsp_ready` is high; then return to IDLE.
  - The non-owner's `rsp_valid` stays 0.
- Flush:
  - A core flush after the core has been granted does not abort the CSR access; a CSR write issued in ISSUE is never undone.
  - Instead a `drop` flag is set. `drop` is sampled continuously from grant through RESP.
  - With `drop` set, RESP asserts no `rsp_valid` and returns to IDLE after one cycle.
  - A flush has no effect on a dbg-owned access.
- `csr_*` outputs other than `csr_valid_o` hold their last latched values when idle.

## Timing
- Accept in cycle T (IDLE).
- `csr_valid_o` in T+1.
- `csr_done_i` in T+2.
- `rsp_valid` in T+3.
- With no back-pressure, back-to-back throughput is one access per 4 cycles.
- Each cycle of `trap_pending_i` in ISSUE adds one cycle of latency.
- A `csr_done_i` arriving outside WAIT is ignored.
- Reset asserted mid-operation: the FSM goes to IDLE on the next edge and any in-flight response is discarded. The CSR file's own state is unaffected by this block.

## Structure
- Shared package `csr_arb_pkg`:
  - `csr_op_e` (RW=01, RS=10, RC=11)
  - `arb_state_e` (IDLE, ISSUE, WAIT, RESP)
  - `owner_e` (CORE, DBG)
  - `csr_req_t` struct holding addr/op/wr/data
- One sub-module, `rr_arb2`: two-input round-robin grant with the `last_grant` register.
- FSM, timeout counter and response registers stay in the top module.

## Test plan
- Single core read of address 0x300, `csr_rdata_i`=0x00001888 at T+2: `core_req_ready_o` in T, `csr_valid_o` only in T+1, `core_rsp_valid_o` in T+3 with `rsp_data_o`=0x00001888, `rsp_excp_o`=0.
- Both requesters valid continuously for 4 accesses: grants in the order core, dbg, core, dbg; never two ready pulses in the same cycle.
- `trap_pending_i` high in T+1 and T+2: `csr_valid_o` first rises in T+3, exactly one cycle wide.
- `csr_done_i` never asserted, TIMEOUT=15: `rsp_valid` 16 cycles after ISSUE, with excp=1 and data=0.
- `core_flush_i` in the WAIT cycle of a core write: `csr_valid_o` pulsed once, no `core_rsp_valid_o`, FSM back in IDLE one cycle after RESP is entered. The same flush during a dbg access: the dbg response is still delivered.
- `cpu_reset_i` during RESP with `rsp_ready`=0: next cycle all outputs are 0 and the state is IDLE; the first grant after reset goes to core on a tie.

Source files
------------

// File: rtl/csr_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_arb_pkg
//  Description : Shared types and constants for the CSR access arbiter:
//                CSR operation encoding, arbiter FSM state encoding,
//                request owner, latched request record and a small helper
//                used by the round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_arb_pkg;

    localparam int c_CSR_ADDR_W = 12;
    localparam int c_CSR_DATA_W = 32;

    // CSR file operation encoding (00 is not a legal operation)
    typedef enum logic [1:0] {
        CSR_OP_RW = 2'b01,
        CSR_OP_RS = 2'b10,
        CSR_OP_RC = 2'b11
    } csr_op_e;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Which requester owns the access in flight
    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DBG  = 1'b1
    } owner_e;

    // Request fields latched at grant time and replayed on the csr_* bus
    typedef struct packed {
        logic [c_CSR_ADDR_W-1:0] addr;
        logic [1:0]              op;
        logic                    wr;
        logic [c_CSR_DATA_W-1:0] data;
    } csr_req_t;

    // The requester that wins a tie is the one not granted last time
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_CORE) ? OWNER_DBG : OWNER_CORE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_access_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_access_arbiter_if
//  Description : Bundle of all handshake and bus signals around the CSR
//                access arbiter: core and debug request/response channels,
//                core flush, trap indication and the CSR file port.
//                modport slave  : the arbiter itself
//                modport master : requesters + CSR file (environment side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_access_arbiter_if;
    import csr_arb_pkg::*;

    // core commit requester
    logic                    core_req_valid_i;
    logic                    core_req_ready_o;
    logic [c_CSR_ADDR_W-1:0] core_req_addr_i;
    logic [1:0]              core_req_op_i;
    logic                    core_req_wr_i;
    logic [c_CSR_DATA_W-1:0] core_req_data_i;
    logic                    core_flush_i;
    logic                    core_rsp_valid_o;
    logic                    core_rsp_ready_i;

    // debug / memory-mapped requester
    logic                    dbg_req_valid_i;
    logic                    dbg_req_ready_o;
    logic [c_CSR_ADDR_W-1:0] dbg_req_addr_i;
    logic [1:0]              dbg_req_op_i;
    logic                    dbg_req_wr_i;
    logic [c_CSR_DATA_W-1:0] dbg_req_data_i;
    logic                    dbg_rsp_valid_o;
    logic                    dbg_rsp_ready_i;

    // shared response payload
    logic [c_CSR_DATA_W-1:0] rsp_data_o;
    logic                    rsp_excp_o;

    // trap / mret updating CSR state this cycle
    logic                    trap_pending_i;

    // CSR file port
    logic                    csr_valid_o;
    logic [c_CSR_ADDR_W-1:0] csr_addr_o;
    logic [1:0]              csr_op_o;
    logic                    csr_wr_o;
    logic [c_CSR_DATA_W-1:0] csr_data_o;
    logic                    csr_done_i;
    logic                    csr_excp_i;
    logic [c_CSR_DATA_W-1:0] csr_rdata_i;

    modport slave (
        input  core_req_valid_i, core_req_addr_i, core_req_op_i, core_req_wr_i,
               core_req_data_i, core_flush_i, core_rsp_ready_i,
               dbg_req_valid_i, dbg_req_addr_i, dbg_req_op_i, dbg_req_wr_i,
               dbg_req_data_i, dbg_rsp_ready_i,
               trap_pending_i, csr_done_i, csr_excp_i, csr_rdata_i,
        output core_req_ready_o, core_rsp_valid_o,
               dbg_req_ready_o, dbg_rsp_valid_o,
               rsp_data_o, rsp_excp_o,
               csr_valid_o, csr_addr_o, csr_op_o, csr_wr_o, csr_data_o
    );

    modport master (
        output core_req_valid_i, core_req_addr_i, core_req_op_i, core_req_wr_i,
               core_req_data_i, core_flush_i, core_rsp_ready_i,
               dbg_req_valid_i, dbg_req_addr_i, dbg_req_op_i, dbg_req_wr_i,
               dbg_req_data_i, dbg_rsp_ready_i,
               trap_pending_i, csr_done_i, csr_excp_i, csr_rdata_i,
        input  core_req_ready_o, core_rsp_valid_o,
               dbg_req_ready_o, dbg_rsp_valid_o,
               rsp_data_o, rsp_excp_o,
               csr_valid_o, csr_addr_o, csr_op_o, csr_wr_o, csr_data_o
    );

endinterface
`default_nettype wire

// File: rtl/csr_access_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin grant. Grants are combinational and
//                only given while i_en is high; the last granted requester
//                is remembered so the other one wins the next tie.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_en          - grant allowed this cycle
//                i_req[0]/[1]  - core / dbg request eligible
//                o_gnt[0]/[1]  - core / dbg granted (one-hot or zero)
//                o_owner       - owner encoding of the current grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import csr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output owner_e     o_owner
);

    owner_e r_last_grant;
    owner_e w_tie_winner;

    assign w_tie_winner = other_owner(r_last_grant);

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = (w_tie_winner == OWNER_DBG) ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    assign o_owner = o_gnt[1] ? OWNER_DBG : OWNER_CORE;

    // Reset to dbg so that core wins the very first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= OWNER_DBG;
        end else if (|o_gnt) begin
            r_last_grant <= o_owner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : csr_access_arbiter
//  Description : Arbitrates core and debug CSR accesses round-robin, issues
//                one single-cycle valid beat per access to the CSR file,
//                waits for done (or times out) and returns data/exception
//                to the originating requester. No beat is issued while a
//                trap/mret is updating CSR state.
//  Ports       : cpu_clock_i  - clock
//                cpu_reset_i  - synchronous active-high reset
//                bus          - csr_access_arbiter_if.slave: request,
//                               response, flush, trap and CSR file signals
//  Parameters  : TIMEOUT      - WAIT cycles without done before a forced
//                               exception response (>= 2)
//                DBG_ENABLE   - 0 disables the debug requester entirely
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_access_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 15,
    parameter bit          DBG_ENABLE = 1'b1
) (
    input  logic                  cpu_clock_i,
    input  logic                  cpu_reset_i,
    csr_access_arbiter_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE  = ARB_IDLE;
    localparam logic [1:0] c_ST_ISSUE = ARB_ISSUE;
    localparam logic [1:0] c_ST_WAIT  = ARB_WAIT;
    localparam logic [1:0] c_ST_RESP  = ARB_RESP;

    localparam int                 c_CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    owner_e                  r_owner;
    csr_req_t                r_req;
    logic                    r_drop;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CSR_DATA_W-1:0] r_rsp_data;
    logic                    r_rsp_excp;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                    w_core_elig;
    logic                    w_dbg_elig;
    logic                    w_arb_en;
    logic [1:0]              w_gnt;
    owner_e                  w_gnt_owner;
    csr_req_t                w_core_req;
    csr_req_t                w_dbg_req;
    logic                    w_issue;
    logic                    w_flush_hit;
    logic                    w_drop;
    logic                    w_in_resp;
    logic                    w_rsp_fire;
    logic [c_CNT_W-1:0]      w_cnt_next;

    // ------------------------------------------------------------------
    // Requester eligibility
    // ------------------------------------------------------------------
    assign w_core_elig = bus.core_req_valid_i & ~bus.core_flush_i;

    if (DBG_ENABLE) begin : g_dbg_on
        assign w_dbg_elig          = bus.dbg_req_valid_i;
        assign bus.dbg_rsp_valid_o = w_in_resp & (r_owner == OWNER_DBG);
    end else begin : g_dbg_off
        assign w_dbg_elig          = 1'b0;
        assign bus.dbg_rsp_valid_o = 1'b0;
    end

    // Grants only from IDLE, never during a trap update or while in reset
    assign w_arb_en = (r_state == c_ST_IDLE) & ~bus.trap_pending_i & ~cpu_reset_i;

    rr_arb2 u_rr_arb2 (
        .clk     (cpu_clock_i),
        .rst     (cpu_reset_i),
        .i_en    (w_arb_en),
        .i_req   ({w_dbg_elig, w_core_elig}),
        .o_gnt   (w_gnt),
        .o_owner (w_gnt_owner)
    );

    assign bus.core_req_ready_o = w_gnt[0];
    assign bus.dbg_req_ready_o  = w_gnt[1];

    assign w_core_req = '{addr: bus.core_req_addr_i, op: bus.core_req_op_i,
                          wr:   bus.core_req_wr_i,   data: bus.core_req_data_i};
    assign w_dbg_req  = '{addr: bus.dbg_req_addr_i,  op: bus.dbg_req_op_i,
                          wr:   bus.dbg_req_wr_i,    data: bus.dbg_req_data_i};

    // ------------------------------------------------------------------
    // CSR file port: the beat is suppressed while a trap updates CSRs so
    // the trap never shadows a CSR write. Fields hold when idle.
    // ------------------------------------------------------------------
    assign w_issue         = (r_state == c_ST_ISSUE) & ~bus.trap_pending_i;
    assign bus.csr_valid_o = w_issue;
    assign bus.csr_addr_o  = r_req.addr;
    assign bus.csr_op_o    = r_req.op;
    assign bus.csr_wr_o    = r_req.wr;
    assign bus.csr_data_o  = r_req.data;

    // ------------------------------------------------------------------
    // Flush handling: the access itself always completes, only the core
    // response is suppressed. The live flush is folded in so a flush in
    // the RESP cycle itself also suppresses the response.
    // ------------------------------------------------------------------
    assign w_flush_hit = (r_owner == OWNER_CORE) & bus.core_flush_i;
    assign w_drop      = r_drop | w_flush_hit;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    assign w_in_resp            = (r_state == c_ST_RESP);
    assign bus.core_rsp_valid_o = w_in_resp & (r_owner == OWNER_CORE) & ~w_drop;
    assign bus.rsp_data_o       = r_rsp_data;
    assign bus.rsp_excp_o       = r_rsp_excp;

    assign w_rsp_fire = (bus.core_rsp_valid_o & bus.core_rsp_ready_i)
                      | (bus.dbg_rsp_valid_o  & bus.dbg_rsp_ready_i);

    assign w_cnt_next = r_cnt + c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            r_state    <= c_ST_IDLE;
            r_owner    <= OWNER_CORE;
            r_req      <= '0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_excp <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|w_gnt) begin
                        r_req   <= w_gnt[0] ? w_core_req : w_dbg_req;
                        r_owner <= w_gnt_owner;
                        r_drop  <= 1'b0;
                        r_state <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    r_drop <= w_drop;
                    if (w_issue) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    r_drop <= w_drop;
                    r_cnt  <= w_cnt_next;
                    if (bus.csr_done_i) begin
                        r_rsp_data <= bus.csr_rdata_i;
                        r_rsp_excp <= bus.csr_excp_i;
                        r_state    <= c_ST_RESP;
                    end else if (w_cnt_next == c_TIMEOUT_CNT) begin
                        // CSR file never answered: report an exception
                        r_rsp_data <= '0;
                        r_rsp_excp <= 1'b1;
                        r_state    <= c_ST_RESP;
                    end
                end

                c_ST_RESP: begin
                    r_drop <= w_drop;
                    // a dropped core response leaves after a single cycle
                    if (w_drop || w_rsp_fire) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_access_arbiter
//  Description : Directed self-checking bench for csr_access_arbiter. A small
//                CSR file model answers every valid beat with done one cycle
//                later (unless disabled for the timeout scenario).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_arbiter;
    import csr_arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // CSR file model controls
    logic        model_en;
    logic [31:0] model_rdata;
    logic        model_excp;
    int          valid_cnt;

    csr_access_arbiter_if bus ();

    csr_access_arbiter #(
        .TIMEOUT    (15),
        .DBG_ENABLE (1'b1)
    ) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CSR file model: done/rdata/excp one cycle after each valid beat
    initial begin : csr_file_model
        logic p;
        valid_cnt       = 0;
        bus.csr_done_i  = 1'b0;
        bus.csr_excp_i  = 1'b0;
        bus.csr_rdata_i = '0;
        forever begin
            @(negedge clk);
            p = (bus.csr_valid_o === 1'b1);
            if (p) valid_cnt++;
            p = p & model_en;
            @(posedge clk);
            #1;
            bus.csr_done_i  = p;
            bus.csr_rdata_i = p ? model_rdata : 32'h0;
            bus.csr_excp_i  = p ? model_excp  : 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({bus.core_req_ready_o, bus.dbg_req_ready_o, bus.core_rsp_valid_o,
             bus.dbg_rsp_valid_o, bus.csr_valid_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus.core_req_ready_o,
                     bus.dbg_req_ready_o, bus.core_rsp_valid_o, bus.dbg_rsp_valid_o, bus.csr_valid_o});
        end
        checks++;
        if ({bus.csr_addr_o, bus.csr_op_o, bus.csr_wr_o, bus.csr_data_o} !== 47'h0) begin
            errors++;
            $display("FAIL reset_csr_bus: got %h expected 0",
                     {bus.csr_addr_o, bus.csr_op_o, bus.csr_wr_o, bus.csr_data_o});
        end
        checks++;
        if ({bus.rsp_data_o, bus.rsp_excp_o} !== 33'h0) begin
            errors++;
            $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_data_o, bus.rsp_excp_o});
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit is_dbg [4];
        int gcyc [4];
        int ngr = 0;
        int cyc = 0;
        int dual = 0;
        int ncore = 0;
        int ndbg = 0;
        model_rdata = 32'h0000_00AA;
        bus.core_rsp_ready_i = 1'b1;
        bus.dbg_rsp_ready_i  = 1'b1;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 12'h340;
        bus.core_req_op_i    = CSR_OP_RW;
        bus.core_req_wr_i    = 1'b1;
        bus.core_req_data_i  = 32'h1111_1111;
        bus.dbg_req_valid_i  = 1'b1;
        bus.dbg_req_addr_i   = 12'h7B1;
        bus.dbg_req_op_i     = CSR_OP_RS;
        bus.dbg_req_wr_i     = 1'b0;
        bus.dbg_req_data_i   = 32'h0;
        while (ngr < 4 && cyc < 64) begin
            @(negedge clk);
            if (bus.core_req_ready_o === 1'b1 && bus.dbg_req_ready_o === 1'b1) dual++;
            if (bus.core_req_ready_o === 1'b1) begin
                is_dbg[ngr] = 1'b0; gcyc[ngr] = cyc; ngr++;
            end else if (bus.dbg_req_ready_o === 1'b1) begin
                is_dbg[ngr] = 1'b1; gcyc[ngr] = cyc; ngr++;
            end
            if (bus.core_rsp_valid_o === 1'b1) ncore++;
            if (bus.dbg_rsp_valid_o === 1'b1) ndbg++;
            step();
            cyc++;
        end
        bus.core_req_valid_i = 1'b0;
        bus.dbg_req_valid_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.core_rsp_valid_o === 1'b1) ncore++;
            if (bus.dbg_rsp_valid_o === 1'b1) ndbg++;
            step();
        end
        checks++;
        if (ngr != 4) begin
            errors++;
            $display("FAIL b2b_grant_count: got %0d expected 4", ngr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (is_dbg[i] != bit'(i % 2)) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got dbg=%0d expected dbg=%0d", i, is_dbg[i], i % 2);
                end
            end
            checks++;
            if (gcyc[3] - gcyc[0] != 12) begin
                errors++;
                $display("FAIL b2b_throughput: got %0d cycles expected 12", gcyc[3] - gcyc[0]);
            end
        end
        checks++;
        if (dual != 0) begin
            errors++;
            $display("FAIL b2b_dual_ready: got %0d cycles expected 0", dual);
        end
        checks++;
        if (ncore != 2 || ndbg != 2) begin
            errors++;
            $display("FAIL b2b_rsp_count: got core=%0d dbg=%0d expected 2/2", ncore, ndbg);
        end
    endtask

    task automatic test_single_read();
        int v0 = valid_cnt;
        model_rdata = 32'h0000_1888;
        model_excp  = 1'b0;
        bus.core_rsp_ready_i = 1'b1;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 12'h300;
        bus.core_req_op_i    = CSR_OP_RS;
        bus.core_req_wr_i    = 1'b0;
        bus.core_req_data_i  = 32'h0;
        @(negedge clk);                        // T
        checks++;
        if (bus.core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_T: got %b expected 1", bus.core_req_ready_o);
        end
        step();
        bus.core_req_valid_i = 1'b0;
        @(negedge clk);                        // T+1
        checks++;
        if (bus.csr_valid_o !== 1'b1 || bus.csr_addr_o !== 12'h300 || bus.csr_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL single_issue: got valid=%b addr=%h wr=%b expected 1/300/0",
                     bus.csr_valid_o, bus.csr_addr_o, bus.csr_wr_o);
        end
        step();
        @(negedge clk);                        // T+2
        checks++;
        if (bus.csr_valid_o !== 1'b0 || bus.core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: got valid=%b rsp=%b expected 0/0",
                     bus.csr_valid_o, bus.core_rsp_valid_o);
        end
        step();
        @(negedge clk);                        // T+3
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1 || bus.dbg_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_valid: got core=%b dbg=%b expected 1/0",
                     bus.core_rsp_valid_o, bus.dbg_rsp_valid_o);
        end
        checks++;
        if (bus.rsp_data_o !== 32'h0000_1888 || bus.rsp_excp_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_data: got %h/%b expected 00001888/0",
                     bus.rsp_data_o, bus.rsp_excp_o);
        end
        step();
        @(negedge clk);                        // T+4
        checks++;
        if (bus.core_rsp_valid_o !== 1'b0 || valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL single_done: got rsp=%b beats=%0d expected 0/1",
                     bus.core_rsp_valid_o, valid_cnt - v0);
        end
        step();
    endtask

    task automatic test_trap_stall();
        int v0 = valid_cnt;
        model_rdata = 32'h1234_5678;
        bus.core_rsp_ready_i = 1'b1;
        bus.trap_pending_i   = 1'b1;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 12'h341;
        bus.core_req_op_i    = CSR_OP_RW;
        bus.core_req_wr_i    = 1'b1;
        bus.core_req_data_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.core_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL trap_blocks_grant: got %b expected 0", bus.core_req_ready_o);
        end
        step();
        bus.trap_pending_i = 1'b0;
        @(negedge clk);                        // T
        checks++;
        if (bus.core_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL trap_grant_T: got %b expected 1", bus.core_req_ready_o);
        end
        step();
        bus.core_req_valid_i = 1'b0;
        bus.trap_pending_i   = 1'b1;
        for (int i = 1; i <= 2; i++) begin     // T+1, T+2
            @(negedge clk);
            checks++;
            if (bus.csr_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL trap_stall_T%0d: got %b expected 0", i, bus.csr_valid_o);
            end
            step();
        end
        bus.trap_pending_i = 1'b0;
        @(negedge clk);                        // T+3
        checks++;
        if (bus.csr_valid_o !== 1'b1 || bus.csr_data_o !== 32'hDEAD_BEEF || bus.csr_wr_o !== 1'b1) begin
            errors++;
            $display("FAIL trap_issue_T3: got valid=%b data=%h wr=%b expected 1/deadbeef/1",
                     bus.csr_valid_o, bus.csr_data_o, bus.csr_wr_o);
        end
        step();
        @(negedge clk);                        // T+4
        checks++;
        if (bus.csr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL trap_pulse_width: got %b expected 0", bus.csr_valid_o);
        end
        step();
        @(negedge clk);                        // T+5
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h1234_5678 || valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL trap_rsp: got valid=%b data=%h beats=%0d expected 1/12345678/1",
                     bus.core_rsp_valid_o, bus.rsp_data_o, valid_cnt - v0);
        end
        step();
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        model_en = 1'b0;
        bus.core_rsp_ready_i = 1'b1;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 12'h342;
        bus.core_req_op_i    = CSR_OP_RS;
        bus.core_req_wr_i    = 1'b0;
        @(negedge clk);                        // T
        step();
        bus.core_req_valid_i = 1'b0;
        @(negedge clk);                        // T+1 (ISSUE)
        checks++;
        if (bus.csr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_issue: got %b expected 1", bus.csr_valid_o);
        end
        while (bus.core_rsp_valid_o !== 1'b1 && n < 40) begin
            step();
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected 16", n);
        end
        checks++;
        if (bus.rsp_data_o !== 32'h0 || bus.rsp_excp_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_payload: got %h/%b expected 00000000/1",
                     bus.rsp_data_o, bus.rsp_excp_o);
        end
        step();
        model_en = 1'b1;
        step();
    endtask

    task automatic test_flush();
        int v0 = valid_cnt;
        model_rdata = 32'hA5A5_0001;
        bus.core_rsp_ready_i = 1'b0;
        bus.dbg_rsp_ready_i  = 1'b0;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 12'h305;
        bus.core_req_op_i    = CSR_OP_RW;
        bus.core_req_wr_i    = 1'b1;
        bus.core_req_data_i  = 32'h8000_0000;
        @(negedge clk);                        // T
        step();
        bus.core_req_valid_i = 1'b0;
        @(negedge clk);                        // T+1 ISSUE
        step();
        bus.core_flush_i = 1'b1;
        @(negedge clk);                        // T+2 WAIT
        step();
        bus.core_flush_i    = 1'b0;
        bus.dbg_req_valid_i = 1'b1;
        bus.dbg_req_addr_i  = 12'h7B0;
        bus.dbg_req_op_i    = CSR_OP_RS;
        bus.dbg_req_wr_i    = 1'b0;
        bus.dbg_req_data_i  = 32'h0;
        @(negedge clk);                        // T+3 RESP (dropped)
        checks++;
        if (bus.core_rsp_valid_o !== 1'b0 || bus.dbg_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp: got rsp=%b dbg_ready=%b expected 0/0",
                     bus.core_rsp_valid_o, bus.dbg_req_ready_o);
        end
        step();
        @(negedge clk);                        // T+4 IDLE again
        checks++;
        if (bus.dbg_req_ready_o !== 1'b1 || bus.core_rsp_valid_o !== 1'b0 || valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL flush_back_idle: got dbg_ready=%b rsp=%b beats=%0d expected 1/0/1",
                     bus.dbg_req_ready_o, bus.core_rsp_valid_o, valid_cnt - v0);
        end
        step();
        bus.dbg_req_valid_i = 1'b0;
        model_rdata = 32'h0000_0042;
        @(negedge clk);                        // T+5 ISSUE (dbg)
        step();
        bus.core_flush_i = 1'b1;
        @(negedge clk);                        // T+6 WAIT
        step();
        bus.core_flush_i = 1'b0;
        @(negedge clk);                        // T+7 RESP
        checks++;
        if (bus.dbg_rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h0000_0042) begin
            errors++;
            $display("FAIL flush_dbg_rsp: got valid=%b data=%h expected 1/00000042",
                     bus.dbg_rsp_valid_o, bus.rsp_data_o);
        end
        step();
        bus.dbg_rsp_ready_i = 1'b1;
        @(negedge clk);                        // T+8 held
        checks++;
        if (bus.dbg_rsp_valid_o !== 1'b1 || bus.core_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_dbg_hold: got dbg=%b core=%b expected 1/0",
                     bus.dbg_rsp_valid_o, bus.core_rsp_valid_o);
        end
        step();
        @(negedge clk);                        // T+9
        checks++;
        if (bus.dbg_rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_dbg_release: got %b expected 0", bus.dbg_rsp_valid_o);
        end
        step();
    endtask

    task automatic test_reset_mid_resp();
        model_rdata = 32'hFFFF_FFFF;
        bus.core_rsp_ready_i = 1'b0;
        bus.dbg_rsp_ready_i  = 1'b0;
        bus.core_req_valid_i = 1'b1;
        bus.core_req_addr_i  = 12'h300;
        bus.core_req_op_i    = CSR_OP_RS;
        bus.core_req_wr_i    = 1'b0;
        @(negedge clk);                        // T
        step();
        bus.core_req_valid_i = 1'b0;
        step();                                // T+2
        step();                                // T+3
        @(negedge clk);
        checks++;
        if (bus.core_rsp_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_resp: got %b expected 1", bus.core_rsp_valid_o);
        end
        step();
        rst = 1'b1;                            // T+4
        step();
        rst = 1'b0;
        @(negedge clk);                        // T+5
        checks++;
        if ({bus.core_req_ready_o, bus.dbg_req_ready_o, bus.core_rsp_valid_o,
             bus.dbg_rsp_valid_o, bus.csr_valid_o, bus.rsp_excp_o} !== 6'b0
            || bus.rsp_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl=%b data=%h expected 000000/0",
                     {bus.core_req_ready_o, bus.dbg_req_ready_o, bus.core_rsp_valid_o,
                      bus.dbg_rsp_valid_o, bus.csr_valid_o, bus.rsp_excp_o}, bus.rsp_data_o);
        end
        checks++;
        if ({bus.csr_addr_o, bus.csr_op_o, bus.csr_wr_o, bus.csr_data_o} !== 47'h0) begin
            errors++;
            $display("FAIL rstmid_csr_bus: got %h expected 0",
                     {bus.csr_addr_o, bus.csr_op_o, bus.csr_wr_o, bus.csr_data_o});
        end
        step();
        bus.core_req_valid_i = 1'b1;
        bus.dbg_req_valid_i  = 1'b1;
        @(negedge clk);                        // T+6 tie after reset
        checks++;
        if (bus.core_req_ready_o !== 1'b1 || bus.dbg_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_tie: got core=%b dbg=%b expected 1/0",
                     bus.core_req_ready_o, bus.dbg_req_ready_o);
        end
        step();
        bus.core_req_valid_i = 1'b0;
        bus.dbg_req_valid_i  = 1'b0;
        bus.core_rsp_ready_i = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        model_en    = 1'b1;
        model_rdata = 32'h0;
        model_excp  = 1'b0;
        bus.core_req_valid_i = 1'b0;
        bus.core_req_addr_i  = '0;
        bus.core_req_op_i    = '0;
        bus.core_req_wr_i    = 1'b0;
        bus.core_req_data_i  = '0;
        bus.core_flush_i     = 1'b0;
        bus.core_rsp_ready_i = 1'b0;
        bus.dbg_req_valid_i  = 1'b0;
        bus.dbg_req_addr_i   = '0;
        bus.dbg_req_op_i     = '0;
        bus.dbg_req_wr_i     = 1'b0;
        bus.dbg_req_data_i   = '0;
        bus.dbg_rsp_ready_i  = 1'b0;
        bus.trap_pending_i   = 1'b0;

        test_reset();
        test_back_to_back();
        test_single_read();
        test_trap_stall();
        test_timeout();
        test_flush();
        test_reset_mid_resp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
